// File: rtl/dram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dram_port_arbiter
//
// Shares the single data-memory port between the single-cycle CPU and a
// DMA/debug requester. The CPU owns the port by default; while the DMA side
// holds the grant the CPU is stalled through CPU_EN_L and the DMA address,
// data and write enable are muxed onto the memory. A per-grant beat limit
// (MAX_BURST) and a minimum CPU run time (MIN_CPU) bound starvation of
// either side.
//
// Ports:
//   CLK        system clock, all state on the rising edge
//   RESET      synchronous, active-low reset
//   CPU_ADDR   CPU data address
//   CPU_DATA   CPU write data
//   CPU_MW     CPU memory write
//   CPU_EN_L   CPU enable, low = run, high = stall
//   DMA_REQ    DMA request / beat valid (level)
//   DMA_ADDR   DMA address
//   DMA_DATA   DMA write data
//   DMA_WE     DMA beat is a write
//   DMA_GNT    DMA owns the port this cycle
//   DMA_Q      registered DMA read data
//   DMA_VALID  one-cycle pulse marking DMA_Q as fresh
//   MEM_ADDR   memory address
//   MEM_DATA   memory write data
//   MEM_MW     memory write enable
//   MEM_Q      memory read data, combinational from MEM_ADDR
// ---------------------------------------------------------------------------
module dram_port_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4,
    parameter int MIN_CPU   = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [DW-1:0] CPU_DATA,
    input  logic          CPU_MW,
    output logic          CPU_EN_L,
    input  logic          DMA_REQ,
    input  logic [AW-1:0] DMA_ADDR,
    input  logic [DW-1:0] DMA_DATA,
    input  logic          DMA_WE,
    output logic          DMA_GNT,
    output logic [DW-1:0] DMA_Q,
    output logic          DMA_VALID,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_DATA,
    output logic          MEM_MW,
    input  logic [DW-1:0] MEM_Q
);

    localparam logic [0:0] S_CPU = 1'b0;
    localparam logic [0:0] S_DMA = 1'b1;

    // Counter widths hold their terminal values without wrapping.
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(MIN_CPU + 1);

    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [CW-1:0] CPU_SAT    = CW'(MIN_CPU);
    // The CPU cycle in flight completes the minimum run, so the hand-over
    // can be decided one count early.
    localparam logic [CW-1:0] CPU_READY  = CW'(MIN_CPU - 1);

    logic [0:0]    state;
    logic [0:0]    state_d;
    logic [BW-1:0] burst_cnt;
    logic [CW-1:0] cpu_cnt;
    logic          dma_owns;
    logic          beat;
    logic          read_beat;
    logic          last_beat;
    logic [DW-1:0] dma_q_p1;
    logic          vld_p1;

    assign dma_owns  = (state == S_DMA);
    assign beat      = dma_owns && DMA_REQ;
    assign read_beat = beat && !DMA_WE;
    assign last_beat = beat && (burst_cnt == BURST_LAST);

    // Next-state: the grant ends on an idle cycle or on the final beat.
    always_comb begin
        state_d = state;
        case (state)
            S_CPU: begin
                if (DMA_REQ && (cpu_cnt >= CPU_READY)) begin
                    state_d = S_DMA;
                end
            end
            S_DMA: begin
                if (!DMA_REQ || last_beat) begin
                    state_d = S_CPU;
                end
            end
            default: state_d = S_CPU;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= S_CPU;
            cpu_cnt   <= '0;
            burst_cnt <= '0;
        end else begin
            state <= state_d;

            // Held at zero for the whole grant, so it starts from zero on
            // every entry to S_CPU.
            if (dma_owns) begin
                cpu_cnt <= '0;
            end else if (cpu_cnt != CPU_SAT) begin
                cpu_cnt <= cpu_cnt + CW'(1);
            end

            // Held at zero while the CPU owns the port, so every grant
            // starts counting from its first beat.
            if (!dma_owns) begin
                burst_cnt <= '0;
            end else if (beat) begin
                burst_cnt <= burst_cnt + BW'(1);
            end
        end
    end

    // ---- stage p1: registered DMA read return ----
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            dma_q_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= read_beat;
            if (read_beat) begin
                dma_q_p1 <= MEM_Q;
            end
        end
    end

    assign DMA_Q     = dma_q_p1;
    assign DMA_VALID = vld_p1;
    assign DMA_GNT   = dma_owns;
    assign CPU_EN_L  = dma_owns;

    // Port mux. The stalled CPU's write strobe is dropped, and no write can
    // reach memory while reset is asserted.
    always_comb begin
        if (dma_owns) begin
            MEM_ADDR = DMA_ADDR;
            MEM_DATA = DMA_DATA;
            MEM_MW   = RESET && DMA_WE && DMA_REQ;
        end else begin
            MEM_ADDR = CPU_ADDR;
            MEM_DATA = CPU_DATA;
            MEM_MW   = RESET && CPU_MW;
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
module tb_dram_port_arbiter;

    localparam int AW        = 8;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
    localparam int MIN_CPU   = 2;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [AW-1:0] CPU_ADDR;
    logic [DW-1:0] CPU_DATA;
    logic          CPU_MW;
    logic          CPU_EN_L;
    logic          DMA_REQ;
    logic [AW-1:0] DMA_ADDR;
    logic [DW-1:0] DMA_DATA;
    logic          DMA_WE;
    logic          DMA_GNT;
    logic [DW-1:0] DMA_Q;
    logic          DMA_VALID;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DATA;
    logic          MEM_MW;
    logic [DW-1:0] MEM_Q;

    always #5 CLK = ~CLK;

    dram_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .MIN_CPU(MIN_CPU)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_ADDR(CPU_ADDR), .CPU_DATA(CPU_DATA), .CPU_MW(CPU_MW),
        .CPU_EN_L(CPU_EN_L),
        .DMA_REQ(DMA_REQ), .DMA_ADDR(DMA_ADDR), .DMA_DATA(DMA_DATA),
        .DMA_WE(DMA_WE), .DMA_GNT(DMA_GNT), .DMA_Q(DMA_Q),
        .DMA_VALID(DMA_VALID),
        .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_MW(MEM_MW),
        .MEM_Q(MEM_Q)
    );

    // Memory behind the port: combinational read, write on the clock edge.
    logic [7:0] mem [256];
    logic       mem_init;
    assign MEM_Q = mem[MEM_ADDR];

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
        end else if (MEM_MW) begin
            mem[MEM_ADDR] <= MEM_DATA;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic gnt, input logic mw,
                             input logic [7:0] addr, input logic [7:0] data,
                             input logic vld, input logic [7:0] q);
        chk({tag, ".gnt"},  32'(DMA_GNT),   32'(gnt));
        chk({tag, ".en_l"}, 32'(CPU_EN_L),  32'(gnt));
        chk({tag, ".mw"},   32'(MEM_MW),    32'(mw));
        chk({tag, ".addr"}, 32'(MEM_ADDR),  32'(addr));
        chk({tag, ".data"}, 32'(MEM_DATA),  32'(data));
        chk({tag, ".vld"},  32'(DMA_VALID), 32'(vld));
        chk({tag, ".q"},    32'(DMA_Q),     32'(q));
    endtask

    task automatic drive(input logic rst, input logic req, input logic we,
                         input logic [7:0] daddr, input logic [7:0] ddata,
                         input logic cmw, input logic [7:0] caddr, input logic [7:0] cdata);
        RESET    = rst;
        DMA_REQ  = req;
        DMA_WE   = we;
        DMA_ADDR = daddr;
        DMA_DATA = ddata;
        CPU_MW   = cmw;
        CPU_ADDR = caddr;
        CPU_DATA = cdata;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Two reset cycles; the first reloads the memory with its known pattern.
    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00);
        mem_init = 1'b1;
        @(negedge CLK);
        chk("reset.mw_forced_low", 32'(MEM_MW), 32'd0);
        next_cycle();
        mem_init = 1'b0;
        next_cycle();
    endtask

    typedef struct {
        logic       rst;
        logic       req;
        logic       we;
        logic [7:0] daddr;
        logic [7:0] ddata;
        logic       cmw;
        logic [7:0] caddr;
        logic [7:0] cdata;
        logic       gnt;
        logic       mw;
        logic [7:0] maddr;
        logic [7:0] mdata;
        logic       vld;
        logic [7:0] q;
    } vec_t;

    vec_t tbl [9];

    // Reference model state for the randomized phase.
    bit         m_gnt;
    int         m_run;
    int         m_beats;
    logic [7:0] m_q;
    bit         m_vld;
    logic [7:0] m_mem [256];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            rst   req   we    daddr  ddata  cmw   caddr  cdata  gnt   mw    maddr  mdata  vld   q
        tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h10, 8'h5A, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b1, 8'h10, 8'h5A, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h20, 8'hA5, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h20, 8'hA5, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 8'h00};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 8'h20, 8'hA5, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 8'h00};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 8'h20, 8'hA5, 1'b1, 8'h33, 8'h77, 1'b1, 1'b1, 8'h20, 8'hA5, 1'b0, 8'h00};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h33, 8'h77, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h44, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'hA5};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0, 8'h44, 8'h00, 1'b0, 8'hA5};

        mem_init = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        next_cycle();
        mem_init = 1'b0;

        // Reset, CPU pass-through, grant latency, write-then-read beat.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].we, tbl[i].daddr, tbl[i].ddata,
                  tbl[i].cmw, tbl[i].caddr, tbl[i].cdata);
            @(negedge CLK);
            check_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].mw, tbl[i].maddr,
                      tbl[i].mdata, tbl[i].vld, tbl[i].q);
            next_cycle();
        end

        // Continuous request: 4 granted, 2 CPU, repeating.
        begin
            int run;
            int total;
            logic prev;
            run = 0; total = 0; prev = 1'b0;
            do_reset();
            for (int k = 0; k < 20; k++) begin
                drive(1'b1, 1'b1, 1'b0, 8'(k), 8'h00, 1'b0, 8'h80, 8'h00);
                @(negedge CLK);
                chk($sformatf("burst.gnt%0d", k), 32'(DMA_GNT), 32'((k % 6) >= 2));
                chk($sformatf("burst.en_l%0d", k), 32'(CPU_EN_L), 32'((k % 6) >= 2));
                if (DMA_GNT && DMA_REQ) begin
                    run++;
                    total++;
                end
                if (prev && !DMA_GNT) begin
                    chk($sformatf("burst.beats_at%0d", k), 32'(run), 32'(MAX_BURST));
                    run = 0;
                end
                prev = DMA_GNT;
                next_cycle();
            end
            chk("burst.total_beats", 32'(total), 32'd12);
        end

        // Request dropped after two beats, then re-requested immediately.
        begin
            bit p5_req [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
            bit p5_gnt [9] = '{0, 0, 1, 1, 1, 0, 0, 1, 1};
            do_reset();
            for (int k = 0; k < 9; k++) begin
                drive(1'b1, p5_req[k], 1'b1, 8'h90, 8'h00, 1'b0, 8'h81, 8'h00);
                @(negedge CLK);
                chk($sformatf("drop.gnt%0d", k), 32'(DMA_GNT), 32'(p5_gnt[k]));
                next_cycle();
            end
        end

        // Reset during the third beat of a read burst.
        begin
            bit         p6_rst [8] = '{1, 1, 1, 1, 0, 1, 1, 1};
            bit         p6_gnt [8] = '{0, 0, 1, 1, 1, 0, 0, 1};
            bit         p6_vld [8] = '{0, 0, 0, 1, 1, 0, 0, 0};
            logic [7:0] p6_q   [8] = '{8'h00, 8'h00, 8'h00, 8'h7C, 8'h7D, 8'h00, 8'h00, 8'h00};
            do_reset();
            for (int k = 0; k < 8; k++) begin
                drive(p6_rst[k], 1'b1, 1'b0, 8'(8'h3E + k), 8'h00, 1'b0, 8'h82, 8'h00);
                @(negedge CLK);
                chk($sformatf("abort.gnt%0d", k), 32'(DMA_GNT), 32'(p6_gnt[k]));
                chk($sformatf("abort.en_l%0d", k), 32'(CPU_EN_L), 32'(p6_gnt[k]));
                chk($sformatf("abort.vld%0d", k), 32'(DMA_VALID), 32'(p6_vld[k]));
                chk($sformatf("abort.q%0d", k), 32'(DMA_Q), 32'(p6_q[k]));
                next_cycle();
            end
        end

        // Randomized traffic against the reference model.
        do_reset();
        m_gnt = 0; m_run = 0; m_beats = 0; m_q = 8'h00; m_vld = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h3C;
        for (int c = 0; c < 400; c++) begin
            logic       rst, req, we, cmw, exp_mw;
            logic [7:0] da, dd, ca, cd, exp_addr, exp_data, rd;
            rst = ($urandom_range(0, 39) != 0);
            req = ($urandom_range(0, 3) != 0);
            we  = 1'($urandom_range(0, 1));
            cmw = 1'($urandom_range(0, 1));
            da  = 8'($urandom_range(0, 15));
            ca  = 8'($urandom_range(0, 15));
            dd  = 8'($urandom);
            cd  = 8'($urandom);
            drive(rst, req, we, da, dd, cmw, ca, cd);

            exp_addr = m_gnt ? da : ca;
            exp_data = m_gnt ? dd : cd;
            exp_mw   = rst && (m_gnt ? (we && req) : cmw);
            @(negedge CLK);
            check_all($sformatf("rnd%0d", c), m_gnt, exp_mw, exp_addr, exp_data, m_vld, m_q);

            if (!rst) begin
                m_gnt = 0; m_run = 0; m_beats = 0; m_q = 8'h00; m_vld = 0;
            end else begin
                rd = m_mem[exp_addr];
                if (exp_mw) m_mem[exp_addr] = exp_data;
                if (m_gnt) begin
                    m_vld = req && !we;
                    if (req && !we) m_q = rd;
                    if (req) m_beats++;
                    if (!req || m_beats == MAX_BURST) begin
                        m_gnt = 0;
                        m_run = 0;
                    end
                end else begin
                    m_vld = 0;
                    m_run++;
                    if (req && m_run >= MIN_CPU) begin
                        m_gnt = 1;
                        m_beats = 0;
                    end
                end
            end
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
